ercm8_acc_stage: RTL and testbench
==================================

Name: ercm8_acc_stage

Overview:
- Streaming accumulator that sits directly downstream of the 8x8 approximate multiplier (ERCM8 family).
- Consumes the 16-bit approximate product on a valid/ready stream and sums products into frames (dot-product style).
- Emits one saturated frame sum, with beat count and overflow flag, per frame through a one-entry output register with valid/ready.
- Used by the error-evaluation and MAC datapaths that compare approximate against exact dot products.

Parameters:
- ACC_W, 24, accumulator and result width in bits; legal range 16..32.
- CNT_W, 8, beat-counter width in bits.
- MAX_LEN, 255, forced frame close after this many beats; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort: discards the in-progress frame.
- prod_vld  input  1  product beat valid.
- prod_dat  input  16  unsigned product (multiplier dat_o).
- prod_last  input  1  final beat of the frame.
- prod_rdy  output  1  beat accepted when prod_vld and prod_rdy are both high.
- acc_vld  output  1  frame result valid.
- acc_dat  output  ACC_W  saturated frame sum.
- acc_cnt  output  CNT_W  number of beats in the frame.
- acc_ovf  output  1  sum saturated at least once in the frame.
- acc_rdy  input  1  downstream accepts the result when acc_vld and acc_rdy are both high.

Behaviour:
- Clock and reset:
  - Single clock: clk.
  - Reset rst_n is asynchronous and active-low. Assertion immediately clears all state and outputs.
  - Reset values: prod_rdy=0, acc_vld=0, acc_dat=0, acc_cnt=0, acc_ovf=0, FSM=IDLE.
  - prod_rdy rises in the first cycle after rst_n deasserts.
- Internal state: accumulator sum (ACC_W), beat count (CNT_W), sticky ovf bit, FSM {IDLE, ACCUM, STALL}.
- Accepting a beat:
  - new_sum = sum + zero-extended prod_dat, computed at ACC_W+1 bits.
  - If bit ACC_W is set, the sum clamps to 2^ACC_W-1 and ovf is set. Once saturated, the sum stays clamped.
  - Count increments by 1.
  - IDLE moves to ACCUM on the first beat.
- Frame close: happens when the accepted beat has prod_last=1, OR when count+1 equals MAX_LEN.
  - If the output register is free (acc_vld=0, or acc_vld=1 and acc_rdy=1 in the same cycle), the final new_sum, count+1 and ovf load into acc_dat, acc_cnt and acc_ovf next cycle, and acc_vld=1 next cycle.
  - Latency: 1 cycle from the last-beat handshake to acc_vld.
  - Accumulator, count and ovf clear; FSM goes to IDLE.
- Backpressure:
  - prod_rdy = (FSM != STALL).
  - A closing beat accepted while the output register is occupied and not draining moves the FSM to STALL, holding the closed result internally.
  - In STALL, prod_rdy=0. When acc_rdy=1, the held result transfers to the output register on that edge. acc_vld stays 1, giving back-to-back frames. The FSM then returns to IDLE.
- Non-closing beats never stall on the output register. A frame can accumulate while the previous result waits.
- Output stability: acc_dat, acc_cnt and acc_ovf hold steady while acc_vld=1 and acc_rdy=0. acc_vld drops the cycle after a handshake if nothing new loads.
- clr:
  - Clears the accumulator, count, ovf and any STALL-held result. FSM goes to IDLE.
  - A beat presented in the same cycle is accepted (prod_rdy unaffected) and discarded.
  - A result already in the output register is unaffected.
- prod_last on the first beat gives a single-beat frame: acc_cnt=1, acc_dat=prod_dat.
- MAX_LEN and prod_last on the same beat count as one close, not two.
- Reset mid-frame or mid-STALL drops all data. There is no partial output.

Test Plan:
- Products 100, 200, 300 with last on 300, acc_rdy=1 → one cycle later acc_vld=1, acc_dat=600, acc_cnt=3, acc_ovf=0; acc_vld=0 the following cycle.
- ACC_W=16, beats 0xFFFF, 0x0001 (last) → acc_dat=0xFFFF, acc_cnt=2, acc_ovf=1; the next frame 5 (last) → acc_dat=5, acc_ovf=0.
- acc_rdy=0, frame A = 10 (last) then frame B = 20, 30 (last) → B's last beat is accepted and the FSM enters STALL with prod_rdy=0. Raising acc_rdy presents A=10 then B=50 on consecutive cycles; prod_rdy returns to 1.
- MAX_LEN=4, six beats of 1 with no prod_last → result acc_dat=4, acc_cnt=4; the remaining two beats start a new frame (count=2 internally).
- Beats 7, 9, then clr together with beat 11, then 3 (last) → acc_dat=3, acc_cnt=1.
- Assert rst_n low mid-frame after beats 50, 60 → outputs go to 0 immediately. After release, 8 (last) → acc_dat=8, acc_cnt=1.

Source files
------------

// File: rtl/ercm8_acc_stage.sv
// ercm8_acc_stage
//   Streaming frame accumulator placed behind the ERCM8 8x8 approximate
//   multiplier. Unsigned 16-bit products are summed, saturating at
//   2^ACC_W-1, into frames. A frame closes on prod_last or when its beat count
//   reaches MAX_LEN. Each closed frame is presented once through a one-entry
//   output register.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. prod_rdy does not depend on prod_vld in the same cycle. A
//   presented result holds acc_dat/acc_cnt/acc_ovf stable until it is taken.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   clr          synchronous abort of the in-progress frame (and any held result)
//   prod_vld/prod_dat/prod_last/prod_rdy   product input stream
//   acc_vld/acc_dat/acc_cnt/acc_ovf/acc_rdy frame result stream
//   dbg_state    current FSM state (IDLE=0, ACCUM=1, STALL=2)
module ercm8_acc_stage #(
   parameter int ACC_W   = 24,
   parameter int CNT_W   = 8,
   parameter int MAX_LEN = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             prod_vld,
   input  logic [15:0]      prod_dat,
   input  logic             prod_last,
   output logic             prod_rdy,
   output logic             acc_vld,
   output logic [ACC_W-1:0] acc_dat,
   output logic [CNT_W-1:0] acc_cnt,
   output logic             acc_ovf,
   input  logic             acc_rdy,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] STALL = 2'd2;

   logic [1:0]       state, state_n;
   logic [ACC_W-1:0] sum, sum_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             ovf, ovf_n;

   // Result of a frame that closed while the output register was occupied.
   logic [ACC_W-1:0] hold_dat, hold_dat_n;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
   logic             hold_ovf, hold_ovf_n;

   logic             vld_n;
   logic [ACC_W-1:0] dat_n;
   logic [CNT_W-1:0] ocnt_n;
   logic             oovf_n;
   logic             rdy_n;

   logic             beat_acc;
   logic [ACC_W:0]   sum_ext;
   logic             sat;
   logic [ACC_W-1:0] beat_sum;
   logic [CNT_W-1:0] beat_cnt;
   logic             beat_ovf;
   logic             close;
   logic             out_free;

   assign beat_acc = prod_vld & prod_rdy;
   // One extra bit catches the carry out; products are unsigned so once the sum
   // has clamped every later beat clamps again.
   assign sum_ext  = {1'b0, sum} + (ACC_W+1)'(prod_dat);
   assign sat      = sum_ext[ACC_W];
   assign beat_sum = sat ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
   assign beat_cnt = cnt + 1'b1;
   assign beat_ovf = ovf | sat;
   // prod_last and the length limit on the same beat is a single close.
   assign close    = beat_acc & (prod_last | (beat_cnt == CNT_W'(MAX_LEN)));
   assign out_free = ~acc_vld | acc_rdy;

   assign dbg_state = state;

   always_comb begin
      state_n    = state;
      sum_n      = sum;
      cnt_n      = cnt;
      ovf_n      = ovf;
      hold_dat_n = hold_dat;
      hold_cnt_n = hold_cnt;
      hold_ovf_n = hold_ovf;
      vld_n      = acc_vld & ~acc_rdy;
      dat_n      = acc_dat;
      ocnt_n     = acc_cnt;
      oovf_n     = acc_ovf;

      if (clr) begin
         // Any beat accepted this cycle is dropped; the output register is
         // left alone and may still drain.
         state_n    = IDLE;
         sum_n      = '0;
         cnt_n      = '0;
         ovf_n      = 1'b0;
         hold_dat_n = '0;
         hold_cnt_n = '0;
         hold_ovf_n = 1'b0;
      end else if (state == STALL) begin
         if (acc_rdy) begin
            vld_n   = 1'b1;
            dat_n   = hold_dat;
            ocnt_n  = hold_cnt;
            oovf_n  = hold_ovf;
            state_n = IDLE;
         end
      end else if (beat_acc) begin
         if (close) begin
            sum_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
            if (out_free) begin
               vld_n   = 1'b1;
               dat_n   = beat_sum;
               ocnt_n  = beat_cnt;
               oovf_n  = beat_ovf;
               state_n = IDLE;
            end else begin
               hold_dat_n = beat_sum;
               hold_cnt_n = beat_cnt;
               hold_ovf_n = beat_ovf;
               state_n    = STALL;
            end
         end else begin
            sum_n   = beat_sum;
            cnt_n   = beat_cnt;
            ovf_n   = beat_ovf;
            state_n = ACCUM;
         end
      end

      // Registered so that ready stays low through reset and rises on the
      // first edge after release.
      rdy_n = (state_n != STALL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sum      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         hold_dat <= '0;
         hold_cnt <= '0;
         hold_ovf <= 1'b0;
         acc_vld  <= 1'b0;
         acc_dat  <= '0;
         acc_cnt  <= '0;
         acc_ovf  <= 1'b0;
         prod_rdy <= 1'b0;
      end else begin
         state    <= state_n;
         sum      <= sum_n;
         cnt      <= cnt_n;
         ovf      <= ovf_n;
         hold_dat <= hold_dat_n;
         hold_cnt <= hold_cnt_n;
         hold_ovf <= hold_ovf_n;
         acc_vld  <= vld_n;
         acc_dat  <= dat_n;
         acc_cnt  <= ocnt_n;
         acc_ovf  <= oovf_n;
         prod_rdy <= rdy_n;
      end
   end

endmodule

// File: tb/tb_ercm8_acc_stage.sv
// Testbench for ercm8_acc_stage (ACC_W=16, MAX_LEN=4 to reach saturation and
// forced closes quickly). Results are predicted by a frame-level model: the
// clamped sum is min(true sum, 2^ACC_W-1), overflow is true sum > 2^ACC_W-1,
// and closed frames wait in an output queue of at most two entries (the
// visible result plus one held while input is stalled).
module tb_ercm8_acc_stage;

   localparam int ACC_W   = 16;
   localparam int CNT_W   = 8;
   localparam int MAX_LEN = 4;
   localparam int EW      = ACC_W + CNT_W + 1;
   localparam longint MAXV = (64'd1 << ACC_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             prod_vld = 1'b0;
   logic [15:0]      prod_dat = '0;
   logic             prod_last = 1'b0;
   logic             prod_rdy;
   logic             acc_vld;
   logic [ACC_W-1:0] acc_dat;
   logic [CNT_W-1:0] acc_cnt;
   logic             acc_ovf;
   logic             acc_rdy = 1'b1;
   logic [1:0]       dbg_state;

   ercm8_acc_stage #(.ACC_W(ACC_W), .CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .prod_vld(prod_vld), .prod_dat(prod_dat), .prod_last(prod_last),
      .prod_rdy(prod_rdy),
      .acc_vld(acc_vld), .acc_dat(acc_dat), .acc_cnt(acc_cnt),
      .acc_ovf(acc_ovf), .acc_rdy(acc_rdy), .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // scoreboard state
   logic [EW-1:0] exp_q[$];   // {ovf, cnt, dat}
   longint        f_sum;
   int            f_cnt;
   bit            rdy_en;
   int            n_chk = 0;
   int            n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      exp_q.delete();
      f_sum  = 0;
      f_cnt  = 0;
      rdy_en = 1'b0;
   endtask

   task automatic check_outputs();
      logic [EW-1:0] r;
      chk("prod_rdy", {31'd0, prod_rdy}, {31'd0, (rdy_en && exp_q.size() < 2)});
      chk("acc_vld", {31'd0, acc_vld}, {31'd0, (exp_q.size() > 0)});
      if (exp_q.size() > 0) begin
         r = exp_q[0];
         chk("acc_dat", 32'(acc_dat), 32'(r[ACC_W-1:0]));
         chk("acc_cnt", 32'(acc_cnt), 32'(r[ACC_W+CNT_W-1:ACC_W]));
         chk("acc_ovf", {31'd0, acc_ovf}, {31'd0, r[EW-1]});
      end
   endtask

   // One clock: predict from pre-edge inputs, advance the model at the edge,
   // check on the falling edge.
   task automatic cycle();
      bit     exp_rdy, acc, drain;
      longint d;
      exp_rdy = rdy_en && (exp_q.size() < 2);
      acc     = prod_vld && exp_rdy;
      drain   = (exp_q.size() > 0) && acc_rdy;
      @(posedge clk);
      if (!rst_n) begin
         reset_model();
      end else begin
         rdy_en = 1'b1;
         if (clr && exp_q.size() == 2) void'(exp_q.pop_back());
         if (drain) void'(exp_q.pop_front());
         if (clr) begin
            f_sum = 0;
            f_cnt = 0;
         end else if (acc) begin
            f_sum += longint'(prod_dat);
            f_cnt++;
            if (prod_last || f_cnt == MAX_LEN) begin
               d = (f_sum > MAXV) ? MAXV : f_sum;
               exp_q.push_back({(f_sum > MAXV), CNT_W'(f_cnt), ACC_W'(d)});
               f_sum = 0;
               f_cnt = 0;
            end
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   // driver tasks
   task automatic beat(input logic [15:0] d, input logic last);
      prod_vld  = 1'b1;
      prod_dat  = d;
      prod_last = last;
      cycle();
      prod_vld  = 1'b0;
      prod_last = 1'b0;
   endtask

   task automatic idle(input int n);
      prod_vld = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      reset_model();
      @(negedge clk);
      // reset values
      chk("rst_acc_dat", 32'(acc_dat), 32'd0);
      chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
      chk("rst_acc_ovf", {31'd0, acc_ovf}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      chk("rdy_after_reset", {31'd0, prod_rdy}, 32'd1);

      // 100+200+300, one-cycle latency, then drop
      acc_rdy = 1'b1;
      beat(16'd100, 1'b0);
      beat(16'd200, 1'b0);
      beat(16'd300, 1'b1);
      chk("t1_dat", 32'(acc_dat), 32'd600);
      chk("t1_cnt", 32'(acc_cnt), 32'd3);
      idle(1);
      chk("t1_drop", {31'd0, acc_vld}, 32'd0);

      // saturation then clean frame
      beat(16'hFFFF, 1'b0);
      beat(16'h0001, 1'b1);
      chk("t2_sat_dat", 32'(acc_dat), 32'h0000FFFF);
      chk("t2_sat_ovf", {31'd0, acc_ovf}, 32'd1);
      beat(16'd5, 1'b1);
      chk("t2_next_dat", 32'(acc_dat), 32'd5);
      chk("t2_next_ovf", {31'd0, acc_ovf}, 32'd0);
      idle(1);

      // backpressure into STALL, then back-to-back drain
      acc_rdy = 1'b0;
      beat(16'd10, 1'b1);
      beat(16'd20, 1'b0);
      beat(16'd30, 1'b1);
      chk("t3_stall_rdy", {31'd0, prod_rdy}, 32'd0);
      chk("t3_a_dat", 32'(acc_dat), 32'd10);
      acc_rdy = 1'b1;
      idle(1);
      chk("t3_b_dat", 32'(acc_dat), 32'd50);
      chk("t3_rdy_back", {31'd0, prod_rdy}, 32'd1);
      idle(2);

      // forced close at MAX_LEN
      for (int i = 0; i < 6; i++) begin
         beat(16'd1, 1'b0);
         if (i == 3) begin
            chk("t4_dat", 32'(acc_dat), 32'd4);
            chk("t4_cnt", 32'(acc_cnt), 32'd4);
         end
      end
      beat(16'd1, 1'b1);
      chk("t4_tail_cnt", 32'(acc_cnt), 32'd3);
      idle(1);

      // clr discards the frame and the beat under it
      beat(16'd7, 1'b0);
      beat(16'd9, 1'b0);
      clr = 1'b1;
      beat(16'd11, 1'b0);
      clr = 1'b0;
      beat(16'd3, 1'b1);
      chk("t5_dat", 32'(acc_dat), 32'd3);
      chk("t5_cnt", 32'(acc_cnt), 32'd1);
      idle(1);

      // asynchronous reset mid-frame with a result waiting
      acc_rdy = 1'b0;
      beat(16'd8, 1'b1);
      beat(16'd50, 1'b0);
      beat(16'd60, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_vld", {31'd0, acc_vld}, 32'd0);
      chk("t6_rst_rdy", {31'd0, prod_rdy}, 32'd0);
      chk("t6_rst_dat", 32'(acc_dat), 32'd0);
      chk("t6_rst_cnt", 32'(acc_cnt), 32'd0);
      chk("t6_rst_ovf", {31'd0, acc_ovf}, 32'd0);
      reset_model();
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      acc_rdy = 1'b1;
      beat(16'd8, 1'b1);
      chk("t6_dat", 32'(acc_dat), 32'd8);
      chk("t6_cnt", 32'(acc_cnt), 32'd1);
      idle(1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         prod_vld  = ($urandom_range(0, 3) != 0);
         prod_dat  = ($urandom_range(0, 3) == 0) ? 16'(16'hF000 + $urandom_range(0, 4095))
                                                 : 16'($urandom_range(0, 65535));
         prod_last = ($urandom_range(0, 4) == 0);
         acc_rdy   = ($urandom_range(0, 9) < 6);
         clr       = ($urandom_range(0, 29) == 0);
         cycle();
      end
      clr      = 1'b0;
      acc_rdy  = 1'b1;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
